// File: rtl/usb_pkg.sv
// usb_pkg: register map, ID value and STATUS bit layout shared by the USB register bank
package usb_pkg;
   localparam logic [7:0] ADDR_ID       = 8'h00;
   localparam logic [7:0] ADDR_CTRL     = 8'h01;
   localparam logic [7:0] ADDR_STATUS   = 8'h02;
   localparam logic [7:0] ADDR_TX_DATA  = 8'h03;
   localparam logic [7:0] ADDR_RX_DATA  = 8'h04;
   localparam logic [7:0] ADDR_RX_COUNT = 8'h05;
   localparam logic [7:0] ADDR_SCRATCH  = 8'h06;
   localparam logic [7:0] ID_VALUE      = 8'hA5;
   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_UNF   = 5;
endpackage

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo: single-clock FIFO; push/pop acceptance is judged on pre-edge occupancy
module usb_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_WIDTH-1:0]        wdata,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_DEPTH):0]  count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == FULL_CNT;
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !rst) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/usb_reg_bank.sv
// usb_reg_bank: EPP-addressed register bank bridging host accesses to TX/RX stream FIFOs.
// Define USB_REG_BANK_OVF_EN to add sticky tx_overflow/rx_underflow flags in STATUS[5:4].
module usb_reg_bank
   import usb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] usbIF_address,
   input  logic                  usbIF_data_write,
   input  logic [DATA_WIDTH-1:0] usb_wdata,
   output logic [DATA_WIDTH-1:0] usbIF_data_in,
   output logic [DATA_WIDTH-1:0] ctrl_out,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic [CW-1:0] tx_count, rx_count;
   logic [DATA_WIDTH-1:0] rx_head, ctrl, scratch, status, rd_val;
   logic [1:0] flags;
   logic wr_tx, wr_rx, wr_ctrl, wr_scratch, unused_tx_count;
   assign wr_tx      = usbIF_data_write && usbIF_address == ADDR_WIDTH'(ADDR_TX_DATA);
   assign wr_rx      = usbIF_data_write && usbIF_address == ADDR_WIDTH'(ADDR_RX_DATA);
   assign wr_ctrl    = usbIF_data_write && usbIF_address == ADDR_WIDTH'(ADDR_CTRL);
   assign wr_scratch = usbIF_data_write && usbIF_address == ADDR_WIDTH'(ADDR_SCRATCH);
   assign unused_tx_count = ^tx_count;
   usb_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_tx),
      .pop   (tx_ready),
      .wdata (usb_wdata),
      .rdata (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );
   usb_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid),
      .pop   (wr_rx),
      .wdata (rx_data),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );
   assign tx_valid = !tx_empty;
   assign rx_ready = !rx_full;
   assign ctrl_out = ctrl;
`ifdef USB_REG_BANK_OVF_EN
   logic wr_status;
   assign wr_status = usbIF_data_write && usbIF_address == ADDR_WIDTH'(ADDR_STATUS);
   // a new event in the same cycle as a W1C wins, so no event is ever lost
   always_ff @(posedge clk)
      if (rst) flags <= '0;
      else begin
         flags[0] <= (wr_tx && tx_full) || (flags[0] && !(wr_status && usb_wdata[ST_TX_OVF]));
         flags[1] <= (wr_rx && rx_empty) || (flags[1] && !(wr_status && usb_wdata[ST_RX_UNF]));
      end
`else
   assign flags = '0;
`endif
   always_comb begin
      status = '0;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_FULL]  = rx_full;
      status[ST_RX_EMPTY] = rx_empty;
      status[ST_TX_OVF]   = flags[0];
      status[ST_RX_UNF]   = flags[1];
   end
   assign rd_val = usbIF_address == ADDR_WIDTH'(ADDR_ID)       ? DATA_WIDTH'(ID_VALUE) :
                   usbIF_address == ADDR_WIDTH'(ADDR_CTRL)     ? ctrl :
                   usbIF_address == ADDR_WIDTH'(ADDR_STATUS)   ? status :
                   usbIF_address == ADDR_WIDTH'(ADDR_RX_DATA)  ? (rx_empty ? '0 : rx_head) :
                   usbIF_address == ADDR_WIDTH'(ADDR_RX_COUNT) ? DATA_WIDTH'(rx_count) :
                   usbIF_address == ADDR_WIDTH'(ADDR_SCRATCH)  ? scratch : '0;
   always_ff @(posedge clk)
      if (rst) begin
         ctrl          <= '0;
         scratch       <= '0;
         usbIF_data_in <= '0;
      end else begin
         usbIF_data_in <= rd_val;
         if (wr_ctrl) ctrl <= usb_wdata;
         if (wr_scratch) scratch <= usb_wdata;
      end
endmodule

// File: tb/tb_usb_reg_bank.sv
// tb_usb_reg_bank: scoreboard bench for usb_reg_bank; honours USB_REG_BANK_OVF_EN when defined
module tb_usb_reg_bank;
   import usb_pkg::*;
   localparam int DEPTH = 16;
`ifdef USB_REG_BANK_OVF_EN
   localparam logic [7:0] OVF = 8'h10, UNF = 8'h20;
`else
   localparam logic [7:0] OVF = 8'h00, UNF = 8'h00;
`endif
   logic clk = 0, rst = 1, usbIF_data_write = 0, tx_valid, tx_ready = 0, rx_valid = 0, rx_ready;
   logic [7:0] usbIF_address = 0, usb_wdata = 0, usbIF_data_in, ctrl_out, tx_data, rx_data = 0;
   logic [7:0] tx_q[$], rx_q[$];
   int checks = 0, errors = 0, tx_pops = 0;
   usb_reg_bank dut (
      .clk              (clk),
      .rst              (rst),
      .usbIF_address    (usbIF_address),
      .usbIF_data_write (usbIF_data_write),
      .usb_wdata        (usb_wdata),
      .usbIF_data_in    (usbIF_data_in),
      .ctrl_out         (ctrl_out),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   // handshakes seen at the negedge complete on the following posedge
   always @(negedge clk)
      if (!rst) begin
         if (tx_valid && tx_ready) begin
            tx_pops++;
            if (tx_q.size() == 0) check("tx_spurious", 1, 0);
            else check("tx_data", tx_data, tx_q.pop_front());
         end
         if (rx_valid && rx_ready) rx_q.push_back(rx_data);
      end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
      usbIF_address = a;
      usb_wdata = d;
      usbIF_data_write = 1;
      if (a == ADDR_TX_DATA && tx_q.size() < DEPTH) tx_q.push_back(d);
      if (a == ADDR_RX_DATA && rx_q.size() != 0) void'(rx_q.pop_front());
      cyc();
      usbIF_data_write = 0;
   endtask
   task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
      usbIF_address = a;
      cyc();
      check(tag, usbIF_data_in, exp);
   endtask
   task automatic drain(input string tag);
      int n = 0;
      tx_ready = 1;
      while (tx_q.size() != 0 && n < 64) begin
         cyc();
         n++;
      end
      check({tag, "_drained"}, tx_q.size(), 0);
      cyc();
      check({tag, "_tx_valid"}, tx_valid, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      int p0;
      repeat (3) cyc();
      check("rst_data_in", usbIF_data_in, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 1);
      rst = 0;
      rd("id", ADDR_ID, 8'hA5);
      rd("ctrl0", ADDR_CTRL, 8'h00);
      rd("status0", ADDR_STATUS, 8'h0A);
      rd("rxcnt0", ADDR_RX_COUNT, 8'h00);
      rd("unmapped", 8'h07, 8'h00);
      host_wr(ADDR_CTRL, 8'h3C);
      check("ctrl_out", ctrl_out, 8'h3C);
      rd("ctrl_rd", ADDR_CTRL, 8'h3C);
      host_wr(ADDR_SCRATCH, 8'h5A);
      rd("scratch", ADDR_SCRATCH, 8'h5A);
      host_wr(ADDR_ID, 8'h00);
      host_wr(ADDR_RX_COUNT, 8'h07);
      rd("id_ro", ADDR_ID, 8'hA5);
      rd("rxcnt_ro", ADDR_RX_COUNT, 8'h00);
      rd("txdata_wo", ADDR_TX_DATA, 8'h00);
      tx_ready = 0;
      for (int i = 0; i <= 16; i++) host_wr(ADDR_TX_DATA, 8'(i));
      rd("status_txfull", ADDR_STATUS, 8'h09 | OVF);
      host_wr(ADDR_STATUS, 8'h10);
      rd("status_ovf_clr", ADDR_STATUS, 8'h09);
      drain("ovf");
      rd("status_drained", ADDR_STATUS, 8'h0A);
      host_wr(ADDR_RX_DATA, 8'h00);
      rd("status_unf", ADDR_STATUS, 8'h0A | UNF);
      host_wr(ADDR_STATUS, 8'h20);
      rd("status_unf_clr", ADDR_STATUS, 8'h0A);
      rx_data = 8'h11;
      rx_valid = 1;
      cyc();
      rx_data = 8'h22;
      cyc();
      rx_valid = 0;
      rd("rxcnt2", ADDR_RX_COUNT, 8'h02);
      rd("rxhead_11", ADDR_RX_DATA, 8'h11);
      host_wr(ADDR_RX_DATA, 8'hFF);
      rd("rxhead_22", ADDR_RX_DATA, 8'h22);
      rd("rxcnt1", ADDR_RX_COUNT, 8'h01);
      for (int i = 0; i < 20; i++) begin
         rx_data = 8'(8'h40 + i);
         rx_valid = 1;
         cyc();
      end
      rx_valid = 0;
      check("rx_ready_full", rx_ready, 0);
      rd("rxcnt_full", ADDR_RX_COUNT, 8'(DEPTH));
      rd("status_rxfull", ADDR_STATUS, 8'h06);
      for (int i = 0; i < DEPTH; i++) begin
         rd("rx_order", ADDR_RX_DATA, rx_q.size() != 0 ? rx_q[0] : 8'h00);
         host_wr(ADDR_RX_DATA, 8'h00);
      end
      rd("rxcnt_empty", ADDR_RX_COUNT, 8'h00);
      rd("rx_empty_read", ADDR_RX_DATA, 8'h00);
      tx_ready = 0;
      for (int i = 0; i < 8; i++) host_wr(ADDR_TX_DATA, 8'(8'h80 + i));
      rd("status_tx8", ADDR_STATUS, 8'h08);
      tx_ready = 1;
      for (int i = 0; i < 20; i++) host_wr(ADDR_TX_DATA, 8'(8'h90 + i));
      tx_ready = 0;
      rd("status_tx8_after", ADDR_STATUS, 8'h08);
      p0 = tx_pops;
      drain("wrap");
      check("wrap_remaining", tx_pops - p0, 8);
      tx_ready = 0;
      host_wr(ADDR_TX_DATA, 8'h77);
      check("pre_rst_tx_valid", tx_valid, 1);
      rst = 1;
      tx_ready = 1;
      tx_q.delete();
      rx_q.delete();
      cyc();
      rst = 0;
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_ctrl", ctrl_out, 0);
      rd("mid_rst_status", ADDR_STATUS, 8'h0A);
      check("mid_rst_tx_valid2", tx_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
